pin_mux_guarded: RTL and testbench
==================================

# pin_mux_guarded

Parametrised pin-multiplexing fabric for the AHB-lite subsystem. It routes FUNCS peripheral functions onto each of COUNT I/O pads. Each pin has its own switch-over state machine: when a pin's selection changes, the pad is driven to high-Z for a guard interval before the new function takes over. Pad inputs pass through a synchroniser and are steered only to the active function.

## Interface
- COUNT, 16: number of pads, 1..32
- FUNCS, 4: functions per pad, power of two, 2..16
- SELW, $clog2(FUNCS): select bits per pad (derived, not overridable)
- GUARD, 2: high-Z guard cycles on switch-over, 0..15
- SYNC_STAGES, 2: input synchroniser depth, 1..3
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- io_in  in  COUNT  pad inputs, asynchronous to clk
- io_out  out  COUNT  pad output data
- io_oeb  out  COUNT  pad output enable, active-low
- p_in  out  COUNT*FUNCS  per-function input; pad i, function f at bit i*FUNCS+f
- p_out  in  COUNT*FUNCS  per-function output data, same indexing
- p_oeb  in  COUNT*FUNCS  per-function output enable (active-low), same indexing
- sel  in  COUNT*SELW  requested function; pad i at bits [i*SELW +: SELW]
- busy  out  COUNT  pad i is in its guard interval

## Operation
- Each pad lane holds these registers:
  - cur_sel: active function.
  - tgt_sel: pending function.
  - cnt: guard counter, 4 bits.
  - state: ACTIVE or GUARD.
  - sync: SYNC_STAGES-deep shift register.
- ACTIVE state:
  - io_out[i] = p_out[i*FUNCS+cur_sel].
  - io_oeb[i] = p_oeb[i*FUNCS+cur_sel].
  - p_in[i*FUNCS+cur_sel] = sync output; every other p_in bit of the lane is 0.
- ACTIVE -> GUARD: on a clock edge where sel_i != cur_sel, with GUARD > 0. The edge loads tgt_sel <= sel_i and cnt <= GUARD-1.
- GUARD state:
  - io_oeb[i] = 1 and io_out[i] = 0.
  - All FUNCS p_in bits of the lane are 0.
  - busy[i] = 1.
- GUARD, sel_i != tgt_sel: tgt_sel <= sel_i and cnt <= GUARD-1 (restart). This takes priority over expiry.
- GUARD, cnt == 0, sel unchanged: cur_sel <= tgt_sel and state -> ACTIVE.
- GUARD, otherwise: cnt decrements.
- sel_i returning to cur_sel during GUARD counts as a new target. The guard still completes, then resumes the old function.
- GUARD = 0: a sel change loads cur_sel directly on the next edge. No high-Z cycle occurs and busy never asserts.
- Lanes are fully independent; simultaneous changes on several pads each run their own guard.
- Reset (rst = 1 at an edge):
  - cur_sel = tgt_sel = 0, cnt = 0, state = ACTIVE, sync = 0.
  - Reset mid-guard aborts the guard.
- While rst is high, io_oeb is forced to all 1 and io_out to all 0 (combinational gate).

## Timing
- Reset values:
  - io_oeb all 1 and io_out all 0 while rst is high.
  - After rst is released: busy = 0, p_in = 0, pads driven by function 0.
- Input latency: an io_in edge appears on p_in exactly SYNC_STAGES clk edges later.
- Output path in ACTIVE: combinational from p_out/p_oeb, zero latency.
- Switch-over, with sel changed before edge k:
  - busy = 1 and pad high-Z from the cycle after edge k through the cycle after edge k+GUARD-1: exactly GUARD cycles.
  - New function drives the pad from the cycle after edge k+GUARD.
- A restart at edge m extends high-Z to GUARD cycles after m.
- sel is sampled each edge. A pulse shorter than one cycle between edges is not seen.

## Structure
- Shared package pin_mux_pkg holds:
  - state encoding localparams ST_ACTIVE = 1'b0 and ST_GUARD = 1'b1.
  - the guard counter width localparam CNT_W = 4.
- Sub-module pin_mux_lane implements one pad: FSM, counter, synchroniser and function steering.
- pin_mux_guarded is a generate loop of COUNT lanes plus the reset output gate.

## Test plan
- Reset and idle (COUNT=16, FUNCS=4, GUARD=2, SYNC_STAGES=2):
  - Hold rst 3 cycles -> io_oeb = 16'hFFFF, io_out = 0.
  - Release with sel = 0 and p_oeb lane-0 bits = 0 -> io_oeb = 0, busy = 0.
- Input steering: pad 3 on function 2, toggle io_in[3] -> p_in[14] follows after exactly 2 edges; p_in[12], p_in[13] and p_in[15] stay 0.
- Switch-over: change sel for pad 5 from 0 to 3 -> busy[5] = 1, io_oeb[5] = 1 and p_in[23:20] = 0 for exactly 2 cycles, then io_out[5] = p_out[23].
- Restart: change pad 5 to 1, then to 2 one cycle later -> guard lasts 2 cycles from the second change; final cur_sel = 2.
- GUARD=0 build: sel change 0 -> 1 -> function 1 drives the pad the cycle after the edge; busy stays 0.
- Reset mid-guard plus simultaneous lanes:
  - Pads 0 and 15 switch on the same edge -> both guard independently.
  - Assert rst during the guard -> cur_sel = 0 and busy = 0 right after the reset edge.

Source files
------------

// File: rtl/pin_mux_pkg.sv
// rtl/pin_mux_pkg.sv - shared constants for the guarded pin-mux fabric
package pin_mux_pkg;

    localparam logic ST_ACTIVE = 1'b0;
    localparam logic ST_GUARD  = 1'b1;

    localparam int CNT_W = 4;

endpackage

// File: rtl/pin_mux_guarded_if.sv
// rtl/pin_mux_guarded_if.sv - pad and per-function signal bundle of the pin-mux fabric
interface pin_mux_guarded_if #(
    parameter int COUNT = 16,
    parameter int FUNCS = 4
) ();
    localparam int SELW = $clog2(FUNCS);

    logic [COUNT-1:0]       io_in;
    logic [COUNT-1:0]       io_out;
    logic [COUNT-1:0]       io_oeb;
    logic [COUNT-1:0]       busy;
    logic [COUNT*FUNCS-1:0] p_in;
    logic [COUNT*FUNCS-1:0] p_out;
    logic [COUNT*FUNCS-1:0] p_oeb;
    logic [COUNT*SELW-1:0]  sel;

    modport master (
        output io_in, p_out, p_oeb, sel,
        input  io_out, io_oeb, p_in, busy
    );

    modport slave (
        input  io_in, p_out, p_oeb, sel,
        output io_out, io_oeb, p_in, busy
    );

endinterface

// File: rtl/pin_mux_lane.sv
// rtl/pin_mux_lane.sv - one pad: switch-over FSM, guard counter, synchroniser, steering
module pin_mux_lane
    import pin_mux_pkg::*;
#(
    parameter int FUNCS       = 4,
    parameter int GUARD       = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_io_in,
    input  logic [$clog2(FUNCS)-1:0]   i_sel,
    input  logic [FUNCS-1:0]           i_p_out,
    input  logic [FUNCS-1:0]           i_p_oeb,
    output logic [FUNCS-1:0]           o_p_in,
    output logic                       o_io_out,
    output logic                       o_io_oeb,
    output logic                       o_busy
);
    localparam int SELW = $clog2(FUNCS);
    localparam logic [CNT_W-1:0] GUARD_LOAD = (GUARD > 0) ? CNT_W'(GUARD - 1) : '0;

    logic                   r_state;
    logic [SELW-1:0]        r_cur_sel;
    logic [SELW-1:0]        r_tgt_sel;
    logic [CNT_W-1:0]       r_cnt;
    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_ACTIVE;
            r_cur_sel <= '0;
            r_tgt_sel <= '0;
            r_cnt     <= '0;
            r_sync    <= '0;
        end else begin
            r_sync[0] <= i_io_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end

            if (r_state == ST_ACTIVE) begin
                if (i_sel != r_cur_sel) begin
                    if (GUARD == 0) begin
                        r_cur_sel <= i_sel;
                    end else begin
                        r_tgt_sel <= i_sel;
                        r_cnt     <= GUARD_LOAD;
                        r_state   <= ST_GUARD;
                    end
                end
            end else begin
                // A new request restarts the guard even if the old one is about to expire
                if (i_sel != r_tgt_sel) begin
                    r_tgt_sel <= i_sel;
                    r_cnt     <= GUARD_LOAD;
                end else if (r_cnt == '0) begin
                    r_cur_sel <= r_tgt_sel;
                    r_state   <= ST_ACTIVE;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_p_in   = '0;
        o_io_out = 1'b0;
        o_io_oeb = 1'b1;
        o_busy   = 1'b1;
        if (r_state == ST_ACTIVE) begin
            o_busy            = 1'b0;
            o_io_out          = i_p_out[r_cur_sel];
            o_io_oeb          = i_p_oeb[r_cur_sel];
            o_p_in[r_cur_sel] = r_sync[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/pin_mux_guarded.sv
// rtl/pin_mux_guarded.sv - COUNT independent guarded pad lanes plus reset output gate
module pin_mux_guarded
    import pin_mux_pkg::*;
#(
    parameter int COUNT       = 16,
    parameter int FUNCS       = 4,
    parameter int GUARD       = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    pin_mux_guarded_if.slave  bus
);
    localparam int SELW = $clog2(FUNCS);

    logic [COUNT-1:0] w_io_out;
    logic [COUNT-1:0] w_io_oeb;

    for (genvar i = 0; i < COUNT; i++) begin : g_lane
        pin_mux_lane #(
            .FUNCS       (FUNCS),
            .GUARD       (GUARD),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_lane (
            .i_clk    (clk),
            .i_rst    (rst),
            .i_io_in  (bus.io_in[i]),
            .i_sel    (bus.sel[i*SELW +: SELW]),
            .i_p_out  (bus.p_out[i*FUNCS +: FUNCS]),
            .i_p_oeb  (bus.p_oeb[i*FUNCS +: FUNCS]),
            .o_p_in   (bus.p_in[i*FUNCS +: FUNCS]),
            .o_io_out (w_io_out[i]),
            .o_io_oeb (w_io_oeb[i]),
            .o_busy   (bus.busy[i])
        );
    end

    // Pads float while reset is held, independent of lane state
    assign bus.io_out = rst ? '0 : w_io_out;
    assign bus.io_oeb = rst ? '1 : w_io_oeb;

endmodule

// File: tb/tb_pin_mux_guarded.sv
// tb/tb_pin_mux_guarded.sv - scoreboard bench for pin_mux_guarded (GUARD=2 and GUARD=0 builds)
module tb_pin_mux_guarded;
    localparam int COUNT = 16;
    localparam int FUNCS = 4;
    localparam int SELW  = 2;
    localparam int SYNC  = 2;
    localparam int G0    = 2;
    localparam int G1    = 0;

    typedef struct packed {
        logic [1:0][15:0] out;
        logic [1:0][15:0] oeb;
        logic [1:0][15:0] busy;
        logic [1:0][63:0] pin;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_drv;
    logic [15:0] io_drv;
    logic [63:0] pout_drv;
    logic [63:0] poeb_drv;
    logic [31:0] sel_drv;

    pin_mux_guarded_if #(.COUNT(COUNT), .FUNCS(FUNCS)) bus0 ();
    pin_mux_guarded_if #(.COUNT(COUNT), .FUNCS(FUNCS)) bus1 ();

    assign bus0.io_in = io_drv;
    assign bus0.p_out = pout_drv;
    assign bus0.p_oeb = poeb_drv;
    assign bus0.sel   = sel_drv;
    assign bus1.io_in = io_drv;
    assign bus1.p_out = pout_drv;
    assign bus1.p_oeb = poeb_drv;
    assign bus1.sel   = sel_drv;

    pin_mux_guarded #(.COUNT(COUNT), .FUNCS(FUNCS), .GUARD(G0), .SYNC_STAGES(SYNC)) dut0 (
        .clk (clk),
        .rst (rst_drv),
        .bus (bus0)
    );

    pin_mux_guarded #(.COUNT(COUNT), .FUNCS(FUNCS), .GUARD(G1), .SYNC_STAGES(SYNC)) dut1 (
        .clk (clk),
        .rst (rst_drv),
        .bus (bus1)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: takeover is scheduled as an absolute edge number (-1 = none pending)
    int          m_cur  [2][COUNT];
    int          m_tgt  [2][COUNT];
    int          m_take [2][COUNT];
    logic [15:0] io_hist[$];
    int          edge_n = 0;
    exp_t        exp_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, want, $time);
        end
    endtask

    task automatic model_edge();
        edge_n++;
        if (rst_drv) begin
            io_hist = {};
            for (int k = 0; k < SYNC; k++) io_hist.push_back('0);
        end else begin
            io_hist.push_back(io_drv);
            void'(io_hist.pop_front());
        end
        for (int d = 0; d < 2; d++) begin
            int g;
            g = (d == 0) ? G0 : G1;
            for (int i = 0; i < COUNT; i++) begin
                int s;
                s = int'(sel_drv[i*SELW +: SELW]);
                if (rst_drv) begin
                    m_cur[d][i]  = 0;
                    m_tgt[d][i]  = 0;
                    m_take[d][i] = -1;
                end else if (m_take[d][i] >= 0) begin
                    if (s != m_tgt[d][i]) begin
                        m_tgt[d][i]  = s;
                        m_take[d][i] = edge_n + g;
                    end else if (edge_n == m_take[d][i]) begin
                        m_cur[d][i]  = m_tgt[d][i];
                        m_take[d][i] = -1;
                    end
                end else if (s != m_cur[d][i]) begin
                    if (g == 0) begin
                        m_cur[d][i] = s;
                    end else begin
                        m_tgt[d][i]  = s;
                        m_take[d][i] = edge_n + g;
                    end
                end
            end
        end
    endtask

    task automatic push_exp();
        exp_t        e;
        logic [15:0] syn;
        e   = '0;
        syn = io_hist[0];
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < COUNT; i++) begin
                if (m_take[d][i] >= 0) begin
                    e.busy[d][i] = 1'b1;
                    e.oeb[d][i]  = 1'b1;
                end else begin
                    e.out[d][i]                     = pout_drv[i*FUNCS + m_cur[d][i]];
                    e.oeb[d][i]                     = poeb_drv[i*FUNCS + m_cur[d][i]];
                    e.pin[d][i*FUNCS + m_cur[d][i]] = syn[i];
                end
            end
            if (rst_drv) begin
                e.out[d] = '0;
                e.oeb[d] = '1;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic r, input logic [31:0] s, input bit rnd_oeb);
        @(posedge clk);
        model_edge();
        #1;
        rst_drv  = r;
        sel_drv  = s;
        io_drv   = 16'($urandom);
        pout_drv = {$urandom, $urandom};
        poeb_drv = rnd_oeb ? {$urandom, $urandom} : 64'h0;
        push_exp();
    endtask

    function automatic logic [31:0] set_sel(input logic [31:0] base, input int pad, input int f);
        logic [31:0] v;
        v = base;
        v[pad*SELW +: SELW] = 2'(f);
        return v;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("g2_io_out", 64'(bus0.io_out), 64'(e.out[0]));
            chk("g2_io_oeb", 64'(bus0.io_oeb), 64'(e.oeb[0]));
            chk("g2_busy",   64'(bus0.busy),   64'(e.busy[0]));
            chk("g2_p_in",   bus0.p_in,        e.pin[0]);
            chk("g0_io_out", 64'(bus1.io_out), 64'(e.out[1]));
            chk("g0_io_oeb", 64'(bus1.io_oeb), 64'(e.oeb[1]));
            chk("g0_busy",   64'(bus1.busy),   64'(e.busy[1]));
            chk("g0_p_in",   bus1.p_in,        e.pin[1]);
        end
    end

    initial begin
        logic [31:0] s;
        rst_drv  = 1'b1;
        io_drv   = '0;
        pout_drv = '0;
        poeb_drv = '1;
        sel_drv  = '0;

        repeat (3) cyc(1'b1, 32'h0, 1'b1);
        repeat (4) cyc(1'b0, 32'h0, 1'b0);

        // pad 3 on function 2, input steering
        s = set_sel(32'h0, 3, 2);
        repeat (8) cyc(1'b0, s, 1'b1);

        // pad 5 switch 0 -> 3, then restart 1 -> 2
        s = set_sel(s, 5, 3);
        repeat (6) cyc(1'b0, s, 1'b1);
        s = set_sel(s, 5, 1);
        cyc(1'b0, s, 1'b1);
        s = set_sel(s, 5, 2);
        repeat (6) cyc(1'b0, s, 1'b1);

        // pads 0 and 15 switch together; guard completes
        s = set_sel(set_sel(s, 0, 1), 15, 3);
        repeat (5) cyc(1'b0, s, 1'b1);

        // simultaneous switch again, reset lands mid-guard
        s = set_sel(set_sel(s, 0, 2), 15, 1);
        cyc(1'b0, s, 1'b1);
        cyc(1'b1, s, 1'b1);
        repeat (3) cyc(1'b0, 32'h0, 1'b1);

        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < COUNT; p++) begin
                if ($urandom_range(0, 7) == 0) s = set_sel(s, p, int'($urandom_range(0, FUNCS-1)));
            end
            cyc(($urandom_range(0, 63) == 0), s, 1'b1);
        end

        repeat (2) @(negedge clk);
        #1;
        chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
